// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//   FSM control unit for the multicycle MIPS-subset CPU. Each instruction is
//   sequenced over several states that share one ALU and one memory port.
//   Memory accesses use a variable-latency ready handshake guarded by a
//   timeout. Unknown instructions trap to a halted ERROR state. A counter
//   tracks retired instructions.
//
// Ports
//   i_clk, i_reset        clock (rising edge), synchronous active-high reset
//   i_opcode, i_funct     IR[31:26], IR[5:0]
//   i_alu_zero            ALU zero flag (same cycle)
//   i_mem_ready           memory completes the current access this cycle
//   o_ir_wr .. o_aluout_wr  write / access strobes
//   o_iord                memory address select: 0=PC, 1=ALUOut
//   o_alu_src_a           0=PC, 1=rs
//   o_alu_src_b           0=rt, 1=const 4, 2=signext, 3=signext<<2
//   o_alu_op              ADD=0, SUB=1, XOR=2, SLT=3
//   o_pc_src              0=ALU result, 1=ALUOut, 2=jump target, 3=rs
//   o_reg_dst             0=rt, 1=rd, 2=r31
//   o_mem_to_reg          0=ALUOut, 1=MDR, 2=PC
//   o_halted, o_err_code  ERROR state flag; 0=none, 1=illegal, 2=mem timeout
//   o_instr_count         retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module multicycle_controller #(
  parameter int ALU_OP_W    = 3,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [5:0]          i_opcode,
  input  logic [5:0]          i_funct,
  input  logic                i_alu_zero,
  input  logic                i_mem_ready,
  output logic                o_ir_wr,
  output logic                o_pc_wr,
  output logic                o_reg_wr,
  output logic                o_mem_rd,
  output logic                o_mem_wr,
  output logic                o_aluout_wr,
  output logic                o_iord,
  output logic                o_alu_src_a,
  output logic [1:0]          o_alu_src_b,
  output logic [ALU_OP_W-1:0] o_alu_op,
  output logic [1:0]          o_pc_src,
  output logic [1:0]          o_reg_dst,
  output logic [1:0]          o_mem_to_reg,
  output logic                o_halted,
  output logic [1:0]          o_err_code,
  output logic [CNT_W-1:0]    o_instr_count
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP, S_JR, S_JAL, S_ERROR
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E, OP_LW   = 6'h23, OP_SW   = 6'h2B;
  localparam logic [5:0] F_JR     = 6'h08, F_ADD   = 6'h20, F_SUB   = 6'h22;
  localparam logic [5:0] F_SLT    = 6'h2A;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_XOR = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_SLT = ALU_OP_W'(3);

  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  // Wide enough to hold MEM_TIMEOUT; the last legal wait value triggers the trap.
  localparam int              WAIT_W       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t              r_state;
  state_t              w_next_state;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [1:0]          r_err_code;
  logic [CNT_W-1:0]    r_instr_count;
  logic                w_timeout;
  logic                w_mem_wait;
  logic                w_err_set;
  logic [1:0]          w_err_val;
  logic                w_retire;

  // This is the final permitted cycle without mem_ready; mem_ready still wins.
  assign w_timeout = (r_wait_cnt == TIMEOUT_LAST);

  // Any return to FETCH from a working state retires one instruction.
  assign w_retire = (w_next_state == S_FETCH) && (r_state != S_FETCH) &&
                    (r_state != S_ERROR);

  assign o_err_code    = r_err_code;
  assign o_instr_count = r_instr_count;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Memory wait counter, sticky error code and retired-instruction counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wait_cnt    <= '0;
      r_err_code    <= 2'd0;
      r_instr_count <= '0;
    end else begin
      // Counts only while a memory state keeps waiting; any state change clears it.
      if (w_mem_wait && !i_mem_ready && (w_next_state == r_state)) begin
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end else begin
        r_wait_cnt <= '0;
      end
      if (w_err_set) begin
        r_err_code <= w_err_val;
      end else begin
        r_err_code <= r_err_code;
      end
      if (w_retire) begin
        r_instr_count <= r_instr_count + CNT_W'(1);
      end else begin
        r_instr_count <= r_instr_count;
      end
    end
  end

  // Next-state and output decode; everything stays 0 while reset is held.
  always_comb begin
    w_next_state = r_state;
    w_err_set    = 1'b0;
    w_err_val    = 2'd0;
    w_mem_wait   = 1'b0;
    o_ir_wr      = 1'b0;
    o_pc_wr      = 1'b0;
    o_reg_wr     = 1'b0;
    o_mem_rd     = 1'b0;
    o_mem_wr     = 1'b0;
    o_aluout_wr  = 1'b0;
    o_iord       = 1'b0;
    o_alu_src_a  = 1'b0;
    o_alu_src_b  = 2'd0;
    o_alu_op     = ALU_ADD;
    o_pc_src     = 2'd0;
    o_reg_dst    = 2'd0;
    o_mem_to_reg = 2'd0;
    o_halted     = 1'b0;
    if (i_reset) begin
      w_next_state = S_FETCH;
    end else begin
      case (r_state)
        S_FETCH: begin
          o_mem_rd    = 1'b1;
          o_alu_src_b = 2'd1;
          w_mem_wait  = 1'b1;
          if (i_mem_ready) begin
            o_ir_wr      = 1'b1;
            o_pc_wr      = 1'b1;
            w_next_state = S_DECODE;
          end else if (w_timeout) begin
            w_next_state = S_ERROR;
            w_err_set    = 1'b1;
            w_err_val    = ERR_TIMEOUT;
          end else begin
            w_next_state = S_FETCH;
          end
        end
        S_DECODE: begin
          // Speculatively compute the branch target into ALUOut.
          o_alu_src_b = 2'd3;
          o_aluout_wr = 1'b1;
          case (i_opcode)
            OP_LW, OP_SW:    w_next_state = S_MEM_ADDR;
            OP_ADDI, OP_XORI: w_next_state = S_I_EXEC;
            OP_BEQ, OP_BNE:  w_next_state = S_BRANCH;
            OP_J:            w_next_state = S_JUMP;
            OP_JAL:          w_next_state = S_JAL;
            OP_RTYPE: begin
              case (i_funct)
                F_ADD, F_SUB, F_SLT: w_next_state = S_R_EXEC;
                F_JR:                w_next_state = S_JR;
                default: begin
                  w_next_state = S_ERROR;
                  w_err_set    = 1'b1;
                  w_err_val    = ERR_ILLEGAL;
                end
              endcase
            end
            default: begin
              w_next_state = S_ERROR;
              w_err_set    = 1'b1;
              w_err_val    = ERR_ILLEGAL;
            end
          endcase
        end
        S_MEM_ADDR: begin
          o_alu_src_a = 1'b1;
          o_alu_src_b = 2'd2;
          o_aluout_wr = 1'b1;
          if (i_opcode == OP_LW) begin
            w_next_state = S_MEM_READ;
          end else begin
            w_next_state = S_MEM_WRITE;
          end
        end
        S_MEM_READ, S_MEM_WRITE: begin
          o_iord     = 1'b1;
          o_mem_rd   = (r_state == S_MEM_READ);
          o_mem_wr   = (r_state == S_MEM_WRITE);
          w_mem_wait = 1'b1;
          if (i_mem_ready) begin
            w_next_state = (r_state == S_MEM_READ) ? S_MEM_WB : S_FETCH;
          end else if (w_timeout) begin
            w_next_state = S_ERROR;
            w_err_set    = 1'b1;
            w_err_val    = ERR_TIMEOUT;
          end else begin
            w_next_state = r_state;
          end
        end
        S_MEM_WB: begin
          o_reg_wr     = 1'b1;
          o_mem_to_reg = 2'd1;
          w_next_state = S_FETCH;
        end
        S_R_EXEC: begin
          o_alu_src_a = 1'b1;
          o_aluout_wr = 1'b1;
          case (i_funct)
            F_SUB:   o_alu_op = ALU_SUB;
            F_SLT:   o_alu_op = ALU_SLT;
            default: o_alu_op = ALU_ADD;
          endcase
          w_next_state = S_R_WB;
        end
        S_R_WB: begin
          o_reg_wr     = 1'b1;
          o_reg_dst    = 2'd1;
          w_next_state = S_FETCH;
        end
        S_I_EXEC: begin
          o_alu_src_a  = 1'b1;
          o_alu_src_b  = 2'd2;
          o_aluout_wr  = 1'b1;
          o_alu_op     = (i_opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
          w_next_state = S_I_WB;
        end
        S_I_WB: begin
          o_reg_wr     = 1'b1;
          w_next_state = S_FETCH;
        end
        S_BRANCH: begin
          // rs - rt; the target was parked in ALUOut during DECODE.
          o_alu_src_a = 1'b1;
          o_alu_op    = ALU_SUB;
          o_pc_src    = 2'd1;
          if (i_opcode == OP_BNE) begin
            o_pc_wr = !i_alu_zero;
          end else begin
            o_pc_wr = i_alu_zero;
          end
          w_next_state = S_FETCH;
        end
        S_JUMP: begin
          o_pc_wr      = 1'b1;
          o_pc_src     = 2'd2;
          w_next_state = S_FETCH;
        end
        S_JR: begin
          o_pc_wr      = 1'b1;
          o_pc_src     = 2'd3;
          w_next_state = S_FETCH;
        end
        S_JAL: begin
          // PC already holds PC+4, which is the link value for r31.
          o_reg_wr     = 1'b1;
          o_reg_dst    = 2'd2;
          o_mem_to_reg = 2'd2;
          o_pc_wr      = 1'b1;
          o_pc_src     = 2'd2;
          w_next_state = S_FETCH;
        end
        S_ERROR: begin
          o_halted     = 1'b1;
          w_next_state = S_ERROR;
        end
        default: begin
          w_next_state = S_ERROR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//   Self-checking bench. A per-instruction reference model expands each
//   instruction (with its memory wait pattern) into the expected sequence of
//   control vectors, and the observed outputs are compared cycle by cycle.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset, alu_zero, mem_ready;
  logic [5:0] opcode, funct;
  logic ir_wr, pc_wr, reg_wr, mem_rd, mem_wr, aluout_wr, iord, alu_src_a, halted;
  logic [1:0] alu_src_b, pc_src, reg_dst, mem_to_reg, err_code;
  logic [2:0] alu_op;
  logic [CNT_W-1:0] instr_count;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.ALU_OP_W(3), .CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .i_clk(clk), .i_reset(reset), .i_opcode(opcode), .i_funct(funct),
    .i_alu_zero(alu_zero), .i_mem_ready(mem_ready),
    .o_ir_wr(ir_wr), .o_pc_wr(pc_wr), .o_reg_wr(reg_wr), .o_mem_rd(mem_rd),
    .o_mem_wr(mem_wr), .o_aluout_wr(aluout_wr), .o_iord(iord),
    .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b), .o_alu_op(alu_op),
    .o_pc_src(pc_src), .o_reg_dst(reg_dst), .o_mem_to_reg(mem_to_reg),
    .o_halted(halted), .o_err_code(err_code), .o_instr_count(instr_count)
  );

  typedef struct packed {
    logic ir_wr, pc_wr, reg_wr, mem_rd, mem_wr, aluout_wr, iord, src_a;
    logic [1:0] src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src, reg_dst, mem_to_reg;
    logic halted;
    logic [1:0] err;
  } out_t;

  out_t act;
  assign act = {ir_wr, pc_wr, reg_wr, mem_rd, mem_wr, aluout_wr, iord, alu_src_a,
                alu_src_b, alu_op, pc_src, reg_dst, mem_to_reg, halted, err_code};

  localparam logic [11:0] LEGAL [12] = '{12'h8C0, 12'hAC0, 12'h020, 12'h022, 12'h02A,
    12'h008, 12'h200, 12'h380, 12'h100, 12'h140, 12'h080, 12'h0C0};

  // ---------------- reference model ----------------
  out_t m_e, m_c;
  out_t exp_q[$];
  out_t care_q[$];
  logic rdy_q[$];
  int   m_count;

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Strobes and status are always checked; mux selects only where they matter.
  function automatic out_t base_care();
    out_t c;
    c = '0;
    c.ir_wr = 1'b1; c.pc_wr = 1'b1; c.reg_wr = 1'b1; c.mem_rd = 1'b1;
    c.mem_wr = 1'b1; c.aluout_wr = 1'b1; c.halted = 1'b1; c.err = 2'b11;
    return c;
  endfunction

  task automatic m_new();
    m_e = '0;
    m_c = base_care();
  endtask

  task automatic m_alu(input logic a, input logic [1:0] b, input logic [2:0] op);
    m_e.src_a = a; m_e.src_b = b; m_e.alu_op = op;
    m_c.src_a = 1'b1; m_c.src_b = 2'b11; m_c.alu_op = 3'b111;
  endtask

  task automatic m_push(input logic rdy);
    exp_q.push_back(m_e);
    care_q.push_back(m_c);
    rdy_q.push_back(rdy);
  endtask

  // Expected control vectors for one whole instruction.
  task automatic m_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input int fw, input int mw);
    for (int i = 0; i <= fw; i++) begin
      m_new(); m_e.mem_rd = 1'b1; m_c.iord = 1'b1; m_alu(1'b0, 2'd1, 3'd0);
      if (i == fw) begin
        m_e.ir_wr = 1'b1; m_e.pc_wr = 1'b1; m_c.pc_src = 2'b11;
      end
      m_push(i == fw);
    end
    m_new(); m_alu(1'b0, 2'd3, 3'd0); m_e.aluout_wr = 1'b1; m_push(rnd_bit());
    case (op)
      6'h23, 6'h2B: begin
        m_new(); m_alu(1'b1, 2'd2, 3'd0); m_e.aluout_wr = 1'b1; m_push(rnd_bit());
        for (int i = 0; i <= mw; i++) begin
          m_new(); m_e.iord = 1'b1; m_c.iord = 1'b1;
          if (op == 6'h23) m_e.mem_rd = 1'b1;
          else m_e.mem_wr = 1'b1;
          m_push(i == mw);
        end
        if (op == 6'h23) begin
          m_new(); m_e.reg_wr = 1'b1; m_e.mem_to_reg = 2'd1;
          m_c.reg_dst = 2'b11; m_c.mem_to_reg = 2'b11; m_push(rnd_bit());
        end
      end
      6'h00: begin
        if (fn == 6'h08) begin
          m_new(); m_e.pc_wr = 1'b1; m_e.pc_src = 2'd3; m_c.pc_src = 2'b11; m_push(rnd_bit());
        end else begin
          m_new(); m_e.aluout_wr = 1'b1;
          m_alu(1'b1, 2'd0, (fn == 6'h22) ? 3'd1 : (fn == 6'h2A) ? 3'd3 : 3'd0);
          m_push(rnd_bit());
          m_new(); m_e.reg_wr = 1'b1; m_e.reg_dst = 2'd1;
          m_c.reg_dst = 2'b11; m_c.mem_to_reg = 2'b11; m_push(rnd_bit());
        end
      end
      6'h08, 6'h0E: begin
        m_new(); m_e.aluout_wr = 1'b1;
        m_alu(1'b1, 2'd2, (op == 6'h0E) ? 3'd2 : 3'd0); m_push(rnd_bit());
        m_new(); m_e.reg_wr = 1'b1;
        m_c.reg_dst = 2'b11; m_c.mem_to_reg = 2'b11; m_push(rnd_bit());
      end
      6'h04, 6'h05: begin
        m_new(); m_alu(1'b1, 2'd0, 3'd1); m_e.pc_src = 2'd1; m_c.pc_src = 2'b11;
        m_e.pc_wr = (op == 6'h04) ? z : !z; m_push(rnd_bit());
      end
      6'h02: begin
        m_new(); m_e.pc_wr = 1'b1; m_e.pc_src = 2'd2; m_c.pc_src = 2'b11; m_push(rnd_bit());
      end
      default: begin
        m_new(); m_e.pc_wr = 1'b1; m_e.pc_src = 2'd2; m_e.reg_wr = 1'b1;
        m_e.reg_dst = 2'd2; m_e.mem_to_reg = 2'd2;
        m_c.pc_src = 2'b11; m_c.reg_dst = 2'b11; m_c.mem_to_reg = 2'b11; m_push(rnd_bit());
      end
    endcase
    m_count++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    out_t e;
    reset = 1'b1; mem_ready = 1'b1; alu_zero = 1'b0; opcode = 6'h23; funct = 6'h00;
    @(negedge clk);
    n_total++;
    if ((act & base_care()) !== '0) $display("FAIL reset_strobes got %h want 0", act & base_care());
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (instr_count !== '0 || err_code !== 2'd0) $display("FAIL reset_regs got cnt=%0d err=%0d want 0/0", instr_count, err_code);
    else n_pass++;
    reset = 1'b0; mem_ready = 1'b0;
    m_new(); m_e.mem_rd = 1'b1; m_c.iord = 1'b1; m_alu(1'b0, 2'd1, 3'd0); e = m_e;
    @(negedge clk);
    n_total++;
    if (((act ^ e) & m_c) !== '0) $display("FAIL reset_fetch got %h want %h", act, e);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_instr_stream();
    logic [5:0] op, fn;
    logic z;
    int fw, mw;
    logic [11:0] pick;
    do_reset();
    m_count = 0;
    for (int n = 0; n < 46; n++) begin
      fw = 0; mw = 0; z = 1'b0; fn = 6'h00;
      case (n)
        0: begin op = 6'h00; fn = 6'h20; end
        1: begin op = 6'h23; mw = 3; end
        2: begin op = 6'h05; z = 1'b1; end
        3: begin op = 6'h05; z = 1'b0; end
        4: begin op = 6'h02; fw = MEM_TIMEOUT - 1; end
        5: begin op = 6'h2B; mw = MEM_TIMEOUT - 1; end
        default: begin
          pick = LEGAL[$urandom_range(0, 11)];
          op = pick[11:6];
          fn = (op == 6'h00) ? pick[5:0] : 6'($urandom_range(0, 63));
          z  = rnd_bit();
          fw = int'($urandom_range(0, 3));
          mw = int'($urandom_range(0, 4));
        end
      endcase
      exp_q.delete(); care_q.delete(); rdy_q.delete();
      m_instr(op, fn, z, fw, mw);
      opcode = op; funct = fn; alu_zero = z;
      for (int k = 0; k < exp_q.size(); k++) begin
        mem_ready = rdy_q[k];
        @(negedge clk);
        n_total++;
        if (((act ^ exp_q[k]) & care_q[k]) !== '0)
          $display("FAIL instr%0d op=%h fn=%h cyc%0d got %h want %h care %h", n, op, fn, k, act, exp_q[k], care_q[k]);
        else n_pass++;
        @(posedge clk); #1;
      end
      n_total++;
      if (instr_count !== CNT_W'(m_count)) $display("FAIL count_instr%0d got %0d want %0d", n, instr_count, CNT_W'(m_count));
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    out_t e;
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      @(negedge clk);
      n_total++;
      if (halted !== 1'b0 || mem_rd !== 1'b1) $display("FAIL timeout_wait%0d got halted=%b mem_rd=%b want 0/1", i, halted, mem_rd);
      else n_pass++;
      @(posedge clk); #1;
    end
    e = '0; e.halted = 1'b1; e.err = 2'd2;
    for (int i = 0; i < 5; i++) begin
      mem_ready = rnd_bit(); alu_zero = rnd_bit(); opcode = LEGAL[i][11:6];
      @(negedge clk);
      n_total++;
      if (((act ^ e) & base_care()) !== '0) $display("FAIL timeout_err%0d got %h want %h", i, act, e);
      else n_pass++;
      @(posedge clk); #1;
    end
    do_reset();
    n_total++;
    if (halted !== 1'b0 || err_code !== 2'd0) $display("FAIL timeout_clear got halted=%b err=%0d want 0/0", halted, err_code);
    else n_pass++;
  endtask

  task automatic test_illegal();
    out_t e;
    logic [11:0] bad [2];
    bad[0] = 12'hFC0;
    bad[1] = 12'h03F;
    e = '0; e.halted = 1'b1; e.err = 2'd1;
    for (int b = 0; b < 2; b++) begin
      do_reset();
      opcode = bad[b][11:6]; funct = bad[b][5:0]; mem_ready = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      for (int i = 0; i < 6; i++) begin
        mem_ready = rnd_bit(); alu_zero = rnd_bit();
        @(negedge clk);
        n_total++;
        if (((act ^ e) & base_care()) !== '0) $display("FAIL illegal%0d_cyc%0d got %h want %h", b, i, act, e);
        else n_pass++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    opcode = 6'h02; mem_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      repeat (3) begin @(posedge clk); #1; end
      n_total++;
      if (instr_count !== CNT_W'((k + 1) % 16)) $display("FAIL wrap%0d got %0d want %0d", k, instr_count, (k + 1) % 16);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    opcode = 6'h2B; mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    @(negedge clk);
    n_total++;
    if (mem_wr !== 1'b1) $display("FAIL midrst_pre got mem_wr=%b want 1", mem_wr);
    else n_pass++;
    reset = 1'b1; opcode = 6'h02;
    #1;
    n_total++;
    if ((act & base_care()) !== '0) $display("FAIL midrst_forced got %h want 0", act & base_care());
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_total++;
      if (mem_wr !== 1'b0 || (i == 0 && (mem_rd !== 1'b1 || iord !== 1'b0)))
        $display("FAIL midrst_after%0d got mem_wr=%b mem_rd=%b iord=%b", i, mem_wr, mem_rd, iord);
      else n_pass++;
      @(posedge clk); #1;
    end
    n_total++;
    if (instr_count !== CNT_W'(2)) $display("FAIL midrst_count got %0d want 2", instr_count);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_instr_stream();
    test_timeout();
    test_illegal();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
